// File: rtl/triangle_scheduler_if.sv
// rtl/triangle_scheduler_if.sv - launch/done handshakes and data buses between the scheduler and the three render stages
interface triangle_scheduler_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int COORD_WIDTH = 16,
    parameter int COLOR_WIDTH = 16
);

    // data fetch stage
    logic                     fetch_start;
    logic [ADDR_WIDTH-1:0]    curr_addr_vertex;
    logic [ADDR_WIDTH-1:0]    curr_addr_color;
    logic [9*COORD_WIDTH-1:0] fetch_vertexes;
    logic [COLOR_WIDTH-1:0]   fetch_color;
    logic                     fetch_eoc;

    // vertex computation stage
    logic                     ver_start;
    logic [9*COORD_WIDTH-1:0] ver_vertexes;
    logic [6*COORD_WIDTH-1:0] ver_vertexes_proj;
    logic [6*COORD_WIDTH-1:0] ver_normal_vectors;
    logic                     ver_eoc;

    // pixel computation stage
    logic                     pix_start;
    logic [6*COORD_WIDTH-1:0] pix_vertexes_proj;
    logic [6*COORD_WIDTH-1:0] pix_normal_vectors;
    logic [COLOR_WIDTH-1:0]   pix_color;
    logic                     pix_eoc;

    // scheduler side
    modport master (
        output fetch_start,
        output curr_addr_vertex,
        output curr_addr_color,
        input  fetch_vertexes,
        input  fetch_color,
        input  fetch_eoc,
        output ver_start,
        output ver_vertexes,
        input  ver_vertexes_proj,
        input  ver_normal_vectors,
        input  ver_eoc,
        output pix_start,
        output pix_vertexes_proj,
        output pix_normal_vectors,
        output pix_color,
        input  pix_eoc
    );

    // render datapath side
    modport slave (
        input  fetch_start,
        input  curr_addr_vertex,
        input  curr_addr_color,
        output fetch_vertexes,
        output fetch_color,
        output fetch_eoc,
        input  ver_start,
        input  ver_vertexes,
        output ver_vertexes_proj,
        output ver_normal_vectors,
        output ver_eoc,
        input  pix_start,
        input  pix_vertexes_proj,
        input  pix_normal_vectors,
        input  pix_color,
        output pix_eoc
    );

endinterface

// File: rtl/triangle_scheduler.sv
// rtl/triangle_scheduler.sv - pipelines one frame of triangles through fetch, vertex and pixel stages
module triangle_scheduler #(
    parameter int ADDR_WIDTH  = 32,
    parameter int COORD_WIDTH = 16,
    parameter int COLOR_WIDTH = 16,
    parameter int VERTEX_SIZE = 6,
    parameter int COLOR_SIZE  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  frame_start,
    input  logic [31:0]           triangles_count,
    input  logic [ADDR_WIDTH-1:0] base_addr_vertex,
    input  logic [ADDR_WIDTH-1:0] base_addr_color,
    output logic                  busy,
    output logic                  frame_end,
    triangle_scheduler_if.master  dp
);

    localparam int VTX_W = 9 * COORD_WIDTH;
    localparam int PRJ_W = 6 * COORD_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] VTX_STRIDE = ADDR_WIDTH'(3 * VERTEX_SIZE);
    localparam logic [ADDR_WIDTH-1:0] COL_STRIDE = ADDR_WIDTH'(COLOR_SIZE);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // frame control and stage bookkeeping
    state_t                state_q,        state_d;
    logic [31:0]           count_q,        count_d;
    logic [31:0]           issued_q,       issued_d;
    logic [31:0]           done_q,         done_d;
    logic                  frame_end_q,    frame_end_d;
    logic                  fetch_start_q,  fetch_start_d;
    logic                  ver_start_q,    ver_start_d;
    logic                  pix_start_q,    pix_start_d;
    logic                  fetch_busy_q,   fetch_busy_d;
    logic                  ver_busy_q,     ver_busy_d;
    logic                  pix_busy_q,     pix_busy_d;
    logic                  fv_q,           fv_d;
    logic                  vv_q,           vv_d;
    logic [ADDR_WIDTH-1:0] addr_vertex_q,  addr_vertex_d;
    logic [ADDR_WIDTH-1:0] addr_color_q,   addr_color_d;

    // handoff and stage-input registers
    logic [VTX_W-1:0]       f_vtx_q,    f_vtx_d;
    logic [COLOR_WIDTH-1:0] f_col_q,    f_col_d;
    logic [VTX_W-1:0]       ver_vtx_q,  ver_vtx_d;
    logic [COLOR_WIDTH-1:0] ver_col_q,  ver_col_d;
    logic [PRJ_W-1:0]       v_proj_q,   v_proj_d;
    logic [PRJ_W-1:0]       v_norm_q,   v_norm_d;
    logic [COLOR_WIDTH-1:0] v_col_q,    v_col_d;
    logic [PRJ_W-1:0]       pix_proj_q, pix_proj_d;
    logic [PRJ_W-1:0]       pix_norm_q, pix_norm_d;
    logic [COLOR_WIDTH-1:0] pix_col_q,  pix_col_d;

    logic run;
    logic fetch_ack;
    logic ver_ack;
    logic pix_ack;
    logic fetch_launch;
    logic ver_launch;
    logic pix_launch;

    // stage acceptance and launch decisions, all evaluated in parallel on registered state
    always_comb begin
        run          = (state_q == ST_RUN);
        fetch_ack    = dp.fetch_eoc & fetch_busy_q;
        ver_ack      = dp.ver_eoc   & ver_busy_q;
        pix_ack      = dp.pix_eoc   & pix_busy_q;
        // the first fetch is decided in the frame_start cycle so its pulse lands one cycle later
        fetch_launch = ((state_q == ST_IDLE) & frame_start & (triangles_count != 32'd0)) |
                       (run & (issued_q < count_q) & ~fetch_busy_q & ~fv_q);
        ver_launch   = run & fv_q & ~ver_busy_q & ~vv_q;
        pix_launch   = run & vv_q & ~pix_busy_q;
    end

    // next-state for the frame FSM, counters, stage-busy flags and handoff valids
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        issued_d      = issued_q;
        done_d        = done_q;
        frame_end_d   = 1'b0;
        fetch_start_d = fetch_launch;
        ver_start_d   = ver_launch;
        pix_start_d   = pix_launch;
        fetch_busy_d  = fetch_busy_q;
        ver_busy_d    = ver_busy_q;
        pix_busy_d    = pix_busy_q;
        fv_d          = fv_q;
        vv_d          = vv_q;
        addr_vertex_d = addr_vertex_q;
        addr_color_d  = addr_color_q;

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    count_d       = triangles_count;
                    issued_d      = 32'd0;
                    done_d        = 32'd0;
                    addr_vertex_d = base_addr_vertex;
                    addr_color_d  = base_addr_color;
                    if (triangles_count == 32'd0) begin
                        frame_end_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (fetch_ack) begin
                    issued_d      = issued_q + 32'd1;
                    addr_vertex_d = addr_vertex_q + VTX_STRIDE;
                    addr_color_d  = addr_color_q + COL_STRIDE;
                end
                if (pix_ack) begin
                    done_d = done_q + 32'd1;
                    if ((done_q + 32'd1) == count_q) begin
                        frame_end_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // launch guards keep ack and launch of the same stage in different cycles
        if (fetch_ack)    fetch_busy_d = 1'b0;
        if (fetch_launch) fetch_busy_d = 1'b1;
        if (ver_ack)      ver_busy_d   = 1'b0;
        if (ver_launch)   ver_busy_d   = 1'b1;
        if (pix_ack)      pix_busy_d   = 1'b0;
        if (pix_launch)   pix_busy_d   = 1'b1;

        // a handoff is only filled while empty, so set and clear never coincide
        if (ver_launch)   fv_d = 1'b0;
        if (fetch_ack)    fv_d = 1'b1;
        if (pix_launch)   vv_d = 1'b0;
        if (ver_ack)      vv_d = 1'b1;
    end

    // data movement through the F and V handoffs and into the held stage inputs
    always_comb begin
        f_vtx_d    = f_vtx_q;
        f_col_d    = f_col_q;
        ver_vtx_d  = ver_vtx_q;
        ver_col_d  = ver_col_q;
        v_proj_d   = v_proj_q;
        v_norm_d   = v_norm_q;
        v_col_d    = v_col_q;
        pix_proj_d = pix_proj_q;
        pix_norm_d = pix_norm_q;
        pix_col_d  = pix_col_q;

        if (fetch_ack) begin
            f_vtx_d = dp.fetch_vertexes;
            f_col_d = dp.fetch_color;
        end
        // color rides alongside the vertex stage so it stays paired with its triangle
        if (ver_launch) begin
            ver_vtx_d = f_vtx_q;
            ver_col_d = f_col_q;
        end
        if (ver_ack) begin
            v_proj_d = dp.ver_vertexes_proj;
            v_norm_d = dp.ver_normal_vectors;
            v_col_d  = ver_col_q;
        end
        if (pix_launch) begin
            pix_proj_d = v_proj_q;
            pix_norm_d = v_norm_q;
            pix_col_d  = v_col_q;
        end
    end

    // control register bank; reset aborts any frame without a frame_end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            count_q       <= 32'd0;
            issued_q      <= 32'd0;
            done_q        <= 32'd0;
            frame_end_q   <= 1'b0;
            fetch_start_q <= 1'b0;
            ver_start_q   <= 1'b0;
            pix_start_q   <= 1'b0;
            fetch_busy_q  <= 1'b0;
            ver_busy_q    <= 1'b0;
            pix_busy_q    <= 1'b0;
            fv_q          <= 1'b0;
            vv_q          <= 1'b0;
            addr_vertex_q <= '0;
            addr_color_q  <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            issued_q      <= issued_d;
            done_q        <= done_d;
            frame_end_q   <= frame_end_d;
            fetch_start_q <= fetch_start_d;
            ver_start_q   <= ver_start_d;
            pix_start_q   <= pix_start_d;
            fetch_busy_q  <= fetch_busy_d;
            ver_busy_q    <= ver_busy_d;
            pix_busy_q    <= pix_busy_d;
            fv_q          <= fv_d;
            vv_q          <= vv_d;
            addr_vertex_q <= addr_vertex_d;
            addr_color_q  <= addr_color_d;
        end
    end

    // datapath register bank
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_vtx_q    <= '0;
            f_col_q    <= '0;
            ver_vtx_q  <= '0;
            ver_col_q  <= '0;
            v_proj_q   <= '0;
            v_norm_q   <= '0;
            v_col_q    <= '0;
            pix_proj_q <= '0;
            pix_norm_q <= '0;
            pix_col_q  <= '0;
        end else begin
            f_vtx_q    <= f_vtx_d;
            f_col_q    <= f_col_d;
            ver_vtx_q  <= ver_vtx_d;
            ver_col_q  <= ver_col_d;
            v_proj_q   <= v_proj_d;
            v_norm_q   <= v_norm_d;
            v_col_q    <= v_col_d;
            pix_proj_q <= pix_proj_d;
            pix_norm_q <= pix_norm_d;
            pix_col_q  <= pix_col_d;
        end
    end

    assign busy                  = (state_q == ST_RUN);
    assign frame_end             = frame_end_q;
    assign dp.fetch_start        = fetch_start_q;
    assign dp.curr_addr_vertex   = addr_vertex_q;
    assign dp.curr_addr_color    = addr_color_q;
    assign dp.ver_start          = ver_start_q;
    assign dp.ver_vertexes       = ver_vtx_q;
    assign dp.pix_start          = pix_start_q;
    assign dp.pix_vertexes_proj  = pix_proj_q;
    assign dp.pix_normal_vectors = pix_norm_q;
    assign dp.pix_color          = pix_col_q;

endmodule

// File: tb/tb_triangle_scheduler.sv
// tb/tb_triangle_scheduler.sv - scoreboard bench for triangle_scheduler
module tb_triangle_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_start;
    logic [31:0] triangles_count;
    logic [31:0] base_addr_vertex;
    logic [31:0] base_addr_color;
    logic        busy;
    logic        frame_end;

    always #5 clk = ~clk;

    triangle_scheduler_if #(.ADDR_WIDTH(32), .COORD_WIDTH(16), .COLOR_WIDTH(16)) dp ();

    triangle_scheduler #(
        .ADDR_WIDTH(32), .COORD_WIDTH(16), .COLOR_WIDTH(16), .VERTEX_SIZE(6), .COLOR_SIZE(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .frame_start(frame_start),
        .triangles_count(triangles_count),
        .base_addr_vertex(base_addr_vertex),
        .base_addr_color(base_addr_color),
        .busy(busy),
        .frame_end(frame_end),
        .dp(dp)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fetch_lat = 3;
    int ver_lat   = 3;
    int pix_lat   = 3;
    int n_fetch = 0;
    int n_ver   = 0;
    int n_pix   = 0;
    int n_fe    = 0;
    int fs_cyc  = 0;
    int last_pix_eoc_cyc = 0;
    bit in_f = 0;
    bit in_v = 0;
    bit in_p = 0;
    bit overlap_seen = 0;

    typedef struct {
        logic [31:0] av;
        logic [31:0] ac;
        int          cyc;
    } fexp_t;

    typedef struct {
        logic [95:0] proj;
        logic [95:0] norm;
        logic [15:0] col;
    } pexp_t;

    fexp_t       q_fetch[$];
    logic [143:0] q_ver[$];
    pexp_t       q_pix[$];
    int          q_fe[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // datapath memory model: vertex words derive from the fetch address
    function automatic logic [143:0] vtx_of(input logic [31:0] a);
        logic [143:0] r;
        for (int k = 0; k < 9; k++) r[k*16 +: 16] = a[15:0] + 16'(k) * 16'h0111;
        return r;
    endfunction

    // vertex stage model: projected x,y of each vertex xored with a marker
    function automatic logic [95:0] proj_of(input logic [143:0] v);
        logic [95:0] r;
        for (int i = 0; i < 3; i++)
            for (int c = 0; c < 2; c++)
                r[(2*i+c)*16 +: 16] = v[(3*i+c)*16 +: 16] ^ 16'h5A5A;
        return r;
    endfunction

    task automatic push_tri(input logic [31:0] av, input logic [31:0] ac, input logic [15:0] col, input int c);
        fexp_t fe;
        pexp_t pe;
        fe.av = av; fe.ac = ac; fe.cyc = c;
        q_fetch.push_back(fe);
        q_ver.push_back(vtx_of(av));
        pe.proj = proj_of(vtx_of(av));
        pe.norm = ~proj_of(vtx_of(av));
        pe.col  = col;
        q_pix.push_back(pe);
    endtask

    task automatic begin_frame(input logic [31:0] n, input logic [31:0] bv, input logic [31:0] bc);
        @(negedge clk);
        fs_cyc           = cyc;
        triangles_count  = n;
        base_addr_vertex = bv;
        base_addr_color  = bc;
        frame_start      = 1'b1;
    endtask

    task automatic end_pulse();
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_fe(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (n_fe < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_frame_end_seen"}, n_fe >= target, 1'b1);
    endtask

    // fetch stage responder
    initial begin : fetch_resp
        logic [31:0] a_v;
        logic [31:0] a_c;
        dp.fetch_eoc = 1'b0;
        dp.fetch_vertexes = '0;
        dp.fetch_color = '0;
        forever begin
            @(negedge clk);
            if (dp.fetch_start === 1'b1) begin
                a_v = dp.curr_addr_vertex;
                a_c = dp.curr_addr_color;
                in_f = 1;
                repeat (fetch_lat) @(negedge clk);
                dp.fetch_vertexes = vtx_of(a_v);
                dp.fetch_color    = ~a_c[15:0];
                dp.fetch_eoc      = 1'b1;
                @(negedge clk);
                dp.fetch_eoc = 1'b0;
                in_f = 0;
            end
        end
    end

    // vertex stage responder
    initial begin : ver_resp
        logic [143:0] v;
        dp.ver_eoc = 1'b0;
        dp.ver_vertexes_proj = '0;
        dp.ver_normal_vectors = '0;
        forever begin
            @(negedge clk);
            if (dp.ver_start === 1'b1) begin
                v = dp.ver_vertexes;
                in_v = 1;
                repeat (ver_lat) @(negedge clk);
                dp.ver_vertexes_proj  = proj_of(v);
                dp.ver_normal_vectors = ~proj_of(v);
                dp.ver_eoc            = 1'b1;
                @(negedge clk);
                dp.ver_eoc = 1'b0;
                in_v = 0;
            end
        end
    end

    // pixel stage responder
    initial begin : pix_resp
        dp.pix_eoc = 1'b0;
        forever begin
            @(negedge clk);
            if (dp.pix_start === 1'b1) begin
                in_p = 1;
                repeat (pix_lat) @(negedge clk);
                dp.pix_eoc = 1'b1;
                last_pix_eoc_cyc = cyc;
                @(negedge clk);
                dp.pix_eoc = 1'b0;
                in_p = 0;
            end
        end
    end

    // monitor: pops the scoreboard whenever the DUT presents a launch or frame_end
    initial begin : monitor
        fexp_t        fe;
        logic [143:0] ve;
        pexp_t        pe;
        int           k;
        forever begin
            @(negedge clk);
            if (in_f && in_v && in_p) overlap_seen = 1;
            if (dp.fetch_start === 1'b1) begin
                n_fetch++;
                check("fetch_expected", q_fetch.size() != 0, 1'b1);
                if (q_fetch.size() != 0) begin
                    fe = q_fetch.pop_front();
                    check("fetch_addr_vertex", dp.curr_addr_vertex, fe.av);
                    check("fetch_addr_color", dp.curr_addr_color, fe.ac);
                    if (fe.cyc >= 0) check("fetch_start_cycle", cyc, fe.cyc);
                end
            end
            if (dp.ver_start === 1'b1) begin
                n_ver++;
                check("ver_expected", q_ver.size() != 0, 1'b1);
                if (q_ver.size() != 0) begin
                    ve = q_ver.pop_front();
                    check("ver_vertexes", dp.ver_vertexes, ve);
                end
            end
            if (dp.pix_start === 1'b1) begin
                n_pix++;
                check("pix_expected", q_pix.size() != 0, 1'b1);
                if (q_pix.size() != 0) begin
                    pe = q_pix.pop_front();
                    check("pix_proj", dp.pix_vertexes_proj, pe.proj);
                    check("pix_normals", dp.pix_normal_vectors, pe.norm);
                    check("pix_color", dp.pix_color, pe.col);
                end
            end
            if (frame_end === 1'b1) begin
                n_fe++;
                check("busy_at_frame_end", busy, 1'b0);
                check("frame_end_expected", q_fe.size() != 0, 1'b1);
                if (q_fe.size() != 0) begin
                    k = q_fe.pop_front();
                    if (k == 0) check("frame_end_cycle_empty", cyc, fs_cyc + 1);
                    else        check("frame_end_cycle", cyc, last_pix_eoc_cyc + 1);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, n_fe=%0d", n_fe);
        $fatal(1, "watchdog");
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_frame_end"}, frame_end, 1'b0);
        check({tag, "_fetch_start"}, dp.fetch_start, 1'b0);
        check({tag, "_ver_start"}, dp.ver_start, 1'b0);
        check({tag, "_pix_start"}, dp.pix_start, 1'b0);
        check({tag, "_curr_addr_vertex"}, dp.curr_addr_vertex, 32'h0);
        check({tag, "_curr_addr_color"}, dp.curr_addr_color, 32'h0);
        check({tag, "_ver_vertexes"}, dp.ver_vertexes, 144'h0);
        check({tag, "_pix_proj"}, dp.pix_vertexes_proj, 96'h0);
        check({tag, "_pix_color"}, dp.pix_color, 16'h0);
    endtask

    initial begin : main
        int b_fetch;
        int b_ver;
        int b_pix;
        int b_fe;
        int k;

        reset_n = 1'b0;
        frame_start = 1'b0;
        triangles_count = '0;
        base_addr_vertex = '0;
        base_addr_color = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // count=0: immediate frame_end, no launches, busy never rises
        b_fetch = n_fetch; b_ver = n_ver; b_pix = n_pix;
        begin_frame(32'd0, 32'h1000, 32'h2000);
        q_fe.push_back(0);
        end_pulse();
        check("empty_busy_low_1", busy, 1'b0);
        @(negedge clk);
        check("empty_busy_low_2", busy, 1'b0);
        wait_fe(1, 10, "empty");
        repeat (5) @(negedge clk);
        check("empty_no_fetch", n_fetch - b_fetch, 0);
        check("empty_no_ver", n_ver - b_ver, 0);
        check("empty_no_pix", n_pix - b_pix, 0);

        // count=1
        b_pix = n_pix;
        begin_frame(32'd1, 32'h1000, 32'h2000);
        push_tri(32'h1000, 32'h2000, 16'hDFFF, fs_cyc + 1);
        q_fe.push_back(1);
        end_pulse();
        check("single_busy", busy, 1'b1);
        wait_fe(2, 200, "single");
        check("single_pix_count", n_pix - b_pix, 1);
        repeat (3) @(negedge clk);

        // count=3: all three stages overlap
        b_pix = n_pix;
        overlap_seen = 0;
        begin_frame(32'd3, 32'h1000, 32'h2000);
        push_tri(32'h1000, 32'h2000, 16'hDFFF, fs_cyc + 1);
        push_tri(32'h1012, 32'h2002, 16'hDFFD, -1);
        push_tri(32'h1024, 32'h2004, 16'hDFFB, -1);
        q_fe.push_back(1);
        end_pulse();
        wait_fe(3, 300, "three");
        check("three_pix_count", n_pix - b_pix, 3);
        check("three_overlap", overlap_seen, 1'b1);
        repeat (3) @(negedge clk);

        // count=4 with a slow pixel stage: both handoffs fill and fetch stalls
        pix_lat = 20;
        b_fetch = n_fetch; b_ver = n_ver; b_pix = n_pix;
        begin_frame(32'd4, 32'h1000, 32'h2000);
        push_tri(32'h1000, 32'h2000, 16'hDFFF, fs_cyc + 1);
        push_tri(32'h1012, 32'h2002, 16'hDFFD, -1);
        push_tri(32'h1024, 32'h2004, 16'hDFFB, -1);
        push_tri(32'h1036, 32'h2006, 16'hDFF9, -1);
        q_fe.push_back(1);
        end_pulse();
        k = 0;
        while (n_pix == b_pix && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("stall_first_pix_seen", n_pix - b_pix, 1);
        repeat (15) @(negedge clk);
        check("stall_fetch_count", n_fetch - b_fetch, 3);
        check("stall_ver_count", n_ver - b_ver, 2);
        wait_fe(4, 400, "stall");
        check("stall_pix_count", n_pix - b_pix, 4);
        pix_lat = 3;
        repeat (3) @(negedge clk);

        // frame_start while running is ignored
        b_fetch = n_fetch; b_fe = n_fe;
        begin_frame(32'd2, 32'h1000, 32'h2000);
        push_tri(32'h1000, 32'h2000, 16'hDFFF, fs_cyc + 1);
        push_tri(32'h1012, 32'h2002, 16'hDFFD, -1);
        q_fe.push_back(1);
        end_pulse();
        repeat (4) @(negedge clk);
        check("midframe_busy", busy, 1'b1);
        triangles_count  = 32'd5;
        base_addr_vertex = 32'h8000;
        base_addr_color  = 32'h9000;
        frame_start      = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wait_fe(b_fe + 1, 300, "midframe");
        repeat (20) @(negedge clk);
        check("midframe_fetch_count", n_fetch - b_fetch, 2);
        check("midframe_single_frame_end", n_fe - b_fe, 1);

        // reset during triangle 1 of 3, then a clean single-triangle frame
        b_fetch = n_fetch;
        begin_frame(32'd3, 32'h1000, 32'h2000);
        push_tri(32'h1000, 32'h2000, 16'hDFFF, fs_cyc + 1);
        push_tri(32'h1012, 32'h2002, 16'hDFFD, -1);
        push_tri(32'h1024, 32'h2004, 16'hDFFB, -1);
        q_fe.push_back(1);
        end_pulse();
        k = 0;
        while (n_fetch - b_fetch < 2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("abort_second_fetch_seen", n_fetch - b_fetch, 2);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        q_fetch.delete();
        q_ver.delete();
        q_pix.delete();
        q_fe.delete();
        b_fe = n_fe;
        repeat (40) @(negedge clk);
        check("abort_no_frame_end", n_fe - b_fe, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        b_pix = n_pix;
        begin_frame(32'd1, 32'h1000, 32'h2000);
        push_tri(32'h1000, 32'h2000, 16'hDFFF, fs_cyc + 1);
        q_fe.push_back(1);
        end_pulse();
        wait_fe(b_fe + 1, 200, "after_reset");
        check("after_reset_pix_count", n_pix - b_pix, 1);

        repeat (10) @(negedge clk);
        check("drain_fetch", q_fetch.size(), 0);
        check("drain_ver", q_ver.size(), 0);
        check("drain_pix", q_pix.size(), 0);
        check("drain_frame_end", q_fe.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/triangle_scheduler.md
Name: triangle_scheduler

Overview:
Sequences one frame of triangles through the three-stage render datapath: data fetch, vertex computation, pixel computation. Latches the frame configuration and walks the vertex and color arrays. Holds inter-stage results in handoff registers so all three stages can work on different triangles at once. Pulses frame_end once the last triangle has left pixel computation.

Parameters:
ADDR_WIDTH, 32, byte-address width
COORD_WIDTH, 16, coordinate word width
COLOR_WIDTH, 16, color word width
VERTEX_SIZE, 6, bytes per vertex; triangle stride = 3*VERTEX_SIZE
COLOR_SIZE, 2, bytes per color entry (one per triangle)

Ports:
clk  in  1  single clock
reset_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle request to render a frame
triangles_count  in  32  triangles in frame, sampled at frame_start
base_addr_vertex  in  ADDR_WIDTH  vertex array base, sampled at frame_start
base_addr_color  in  ADDR_WIDTH  color array base, sampled at frame_start
busy  out  1  frame in progress
frame_end  out  1  one-cycle pulse, frame done
fetch_start  out  1  fetch launch pulse
curr_addr_vertex  out  ADDR_WIDTH  vertex address of current fetch
curr_addr_color  out  ADDR_WIDTH  color address of current fetch
fetch_vertexes  in  9*COORD_WIDTH  fetched [v][xyz]; element (3v+c) at bits (3v+c)*COORD_WIDTH
fetch_color  in  COLOR_WIDTH  fetched color
fetch_eoc  in  1  fetch done pulse
ver_start  out  1  vertex launch pulse
ver_vertexes  out  9*COORD_WIDTH  vertex stage input, packed as fetch_vertexes
ver_vertexes_proj  in  6*COORD_WIDTH  projected [v][xy]; element (2v+c)
ver_normal_vectors  in  6*COORD_WIDTH  edge normals, packed as proj
ver_eoc  in  1  vertex done pulse
pix_start  out  1  pixel launch pulse
pix_vertexes_proj  out  6*COORD_WIDTH  pixel stage input
pix_normal_vectors  out  6*COORD_WIDTH  pixel stage input
pix_color  out  COLOR_WIDTH  pixel stage input
pix_eoc  in  1  pixel done pulse

Behaviour:
- Reset: all outputs 0; counters, handoff valids (fv, vv) and the three stage-busy flags clear. Reset mid-frame aborts the frame silently, with no frame_end.
- Top FSM has two states, IDLE and RUN. In IDLE, frame_start latches count and both bases, clears issued and done, and enters RUN; busy=1 from the next cycle. frame_start in RUN is ignored.
- Fetch launch: in RUN with issued<count, fetch not busy and fv=0:
  - fetch_start is high for one cycle, starting one cycle after frame_start for the first triangle.
  - curr_addr_* are valid from the fetch_start cycle and held until fetch_eoc.
- On fetch_eoc:
  - F register <= fetch_vertexes and fetch_color; fv=1; issued++.
  - curr_addr_vertex += 3*VERTEX_SIZE; curr_addr_color += COLOR_SIZE. Adds are modulo 2^ADDR_WIDTH.
- Vertex launch: fv=1 and vertex not busy and vv=0.
  - ver_start pulses for one cycle.
  - ver_vertexes and a color hold register load from F in that same cycle; both are held stable until ver_eoc.
  - fv clears.
- On ver_eoc: V register <= proj, normals, held color; vv=1.
- Pixel launch: vv=1 and pixel not busy.
  - pix_start pulses for one cycle.
  - pix_* load from V in that same cycle and are held until pix_eoc.
  - vv clears.
- On pix_eoc: done++. If done reaches count, frame_end pulses on the next cycle, busy drops the same cycle, and the FSM returns to IDLE.
- count=0: frame_end pulses 1 cycle after frame_start; no start pulses are issued.
- Simultaneous events: all stages are evaluated in parallel each cycle. A stage's eoc and a downstream launch in the same cycle are both honoured.
- The fv=0 / vv=0 launch guards guarantee no handoff register is overwritten.
- An eoc arriving while its stage is not busy is ignored.
- Counters are 32-bit.

Test Plan:
- count=0, frame_start -> frame_end pulses 1 cycle later; no fetch_start, ver_start or pix_start; busy stays 0.
- count=1, base_vertex=0x1000, base_color=0x2000, each stage eoc 3 cycles after its start:
  - fetch_start 1 cycle after frame_start with addresses 0x1000/0x2000.
  - ver_vertexes equal the fetched data.
  - pix_color equals the fetched color.
  - frame_end 1 cycle after pix_eoc.
- count=3, same bases: fetch addresses 0x1000/0x2000, 0x1012/0x2002, 0x1024/0x2004. Triangle 2's fetch overlaps triangle 1's vertex stage, which overlaps triangle 0's pixel stage. Exactly 3 pix_start pulses.
- count=4, pixel stage takes 20 cycles per triangle:
  - fetch stalls with fv=1 and vv=1.
  - No handoff data is corrupted.
  - Per-triangle colors arrive at pix_color in order.
- frame_start pulsed mid-frame with a different count -> ignored; the original count completes.
- reset_n low during triangle 1 of 3 -> all outputs 0 immediately. A later frame_start with count=1 then runs cleanly from base addresses.
